// File: rtl/adder_resp_pkg.sv
// Shared types and constants for the adder responder.
package adder_resp_pkg;

    localparam int DATA_W    = 64;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 8;
    localparam int COUNT_W   = 32;

    // One queued response at the default tag width. The FIFO carries the
    // same field order flattened: {result, carry, tag}, MSB first.
    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic                 carry;
        logic [TAG_W_DEF-1:0] tag;
    } rsp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; storage is not reset.
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Reset blocks writes so a request presented during reset never lands.
    assign push_ok = push_i && !full_o && !rst_i;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/adder_responder.sv
// Valid/ready request-response adder: 65-bit sum queued with its tag, returned in order.
module adder_responder
    import adder_resp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_carry,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [COUNT_W-1:0] req_count
);

    localparam int ENTRY_W = DATA_W + 1 + TAG_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [DATA_W:0]      sum;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [ENTRY_W-1:0]   out_entry;
    logic [ENTRY_W-1:0]   hold_q, hold_d;
    logic [COUNT_W-1:0]   req_count_q, req_count_d;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign sum        = {1'b0, req_a} + {1'b0, req_b};
    assign push_entry = {sum[DATA_W-1:0], sum[DATA_W], req_tag};

    // Both handshake flags depend only on registered occupancy.
    assign req_ready = (fifo_count < CNT_W'(DEPTH));
    assign rsp_valid = !fifo_empty;
    assign push      = req_valid && !fifo_full && !rst;
    assign pop       = rsp_valid && rsp_ready;

    resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Remember the most recent head so outputs stay put once the FIFO drains.
    always_comb begin
        hold_d      = hold_q;
        req_count_d = req_count_q;
        if (rsp_valid) begin
            hold_d = head_entry;
        end
        if (push) begin
            req_count_d = req_count_q + COUNT_W'(1);
        end
    end

    // Held head and request counter; reset clears both so outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            req_count_q <= '0;
        end else begin
            hold_q      <= hold_d;
            req_count_q <= req_count_d;
        end
    end

    assign out_entry = rsp_valid ? head_entry : hold_q;
    assign {rsp_result, rsp_carry, rsp_tag} = out_entry;
    assign req_count = req_count_q;

endmodule

// File: doc/adder_responder.md
ADDER_RESPONDER -- requirements
Module: adder_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, response FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 8, request/response tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept request.
REQ-007 SHALL have port req_a  input  64  operand A, unsigned.
REQ-008 SHALL have port req_b  input  64  operand B, unsigned.
REQ-009 SHALL have port req_tag  input  TAG_W  caller transaction tag.
REQ-010 SHALL have port rsp_valid  output  1  response present at FIFO head.
REQ-011 SHALL have port rsp_ready  input  1  caller accepts response.
REQ-012 SHALL have port rsp_result  output  64  (A+B) mod 2^64.
REQ-013 SHALL have port rsp_carry  output  1  carry-out of the 64-bit add.
REQ-014 SHALL have port rsp_tag  output  TAG_W  tag echoed from matching request.
REQ-015 SHALL have port req_count  output  32  total accepted requests, wrapping.

Function
REQ-016 SHALL accept a request on a clk edge where req_valid && req_ready; req_* SHALL be ignored otherwise.
REQ-017 SHALL compute {carry, result} = {1'b0,A} + {1'b0,B} as a 65-bit sum and write it with the tag into the FIFO tail on the accepting edge.
REQ-018 SHALL assert rsp_valid one cycle after acceptance into an empty FIFO (latency 1 cycle).
REQ-019 SHALL drive rsp_result/rsp_carry/rsp_tag from the FIFO head whenever rsp_valid=1; values undefined-but-stable while rsp_valid=0 (hold last head).
REQ-020 SHALL pop the head on an edge where rsp_valid && rsp_ready.
REQ-021 SHALL deliver responses strictly in acceptance order.
REQ-022 SHALL drive req_ready = (occupancy < DEPTH), registered-state only, no combinational path from rsp_ready or req_valid.
REQ-023 Full with simultaneous pop: req_ready stays 0 that cycle; no request lost, no push.
REQ-024 Simultaneous push and pop when 0<occupancy<DEPTH: occupancy unchanged, both take effect.
REQ-025 Push into empty FIFO while rsp_ready=1: new entry not popped the same edge (rsp_valid was 0).
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 req_count SHALL increment by 1 per accepted request and wrap 0xFFFFFFFF -> 0.
REQ-028 rsp_valid/req_ready SHALL hold stable while the other side stalls (AXI-style valid/ready; valid never drops without a pop).

Reset
REQ-029 On rst=1 at an edge: occupancy=0, pointers=0, rsp_valid=0, req_ready=1 the next cycle, req_count=0, rsp_result=0, rsp_carry=0, rsp_tag=0.
REQ-030 Reset mid-operation SHALL discard all queued responses; a request presented during reset SHALL NOT be accepted.
REQ-031 rst SHALL take priority over concurrent push/pop.

Structure
REQ-032 Package adder_resp_pkg SHALL hold: rsp_entry_t struct {result[63:0], carry, tag}, DEPTH default constant, DATA_W=64.
REQ-033 FIFO SHALL be a sub-module resp_fifo (parameterised depth/width, push/pop/full/empty/count); arithmetic stays in adder_responder.

Verification
REQ-034 Single: A=5, B=7, tag=0x11, rsp_ready=1 -> next cycle rsp_valid=1, result=12, carry=0, tag=0x11; req_count=1.
REQ-035 Overflow: A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> result=1, carry=1.
REQ-036 Backpressure: rsp_ready=0, 5 back-to-back requests, DEPTH=4 -> req_ready=0 after 4th accept, 5th held; release rsp_ready -> 5 responses, tags in order.
REQ-037 Streaming: req_valid=1 and rsp_ready=1 continuously for 100 cycles -> 1 response/cycle after 1-cycle latency, occupancy never exceeds 1.
REQ-038 Reset mid-stream: 3 entries queued, pulse rst 1 cycle -> rsp_valid=0, req_count=0, req_ready=1 next cycle; no stale response emerges.
REQ-039 Wrap: preload req_count to 0xFFFFFFFF via 2^32-1 accepts (or force) -> next accept gives req_count=0.
